// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED share arbiter.
// FSM state encodings are plain localparams so older tooling can consume them.
package led_arb_pkg;

   localparam int LED_DATA_W = 8;

   typedef logic [0:0] arb_state_t;

   localparam arb_state_t IDLE = 1'b0;
   localparam arb_state_t HOLD = 1'b1;

   // An index must always be at least one bit wide, even for two requesters.
   function automatic int owner_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/led_share_arbiter_rr_pick.sv
// Combinational round-robin picker: the first valid request at or after rr_ptr wins.
module rr_pick
   import led_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any_valid
);

   int idx;

   // Walk offsets from the far end back toward rr_ptr so the nearest valid request overwrites the rest.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_valid = 1'b0;
      idx       = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (req[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
            grant_idx  = IDX_W'(idx);
            any_valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/led_share_arbiter.sv
// Round-robin owner of the shared LED bank with a minimum dwell per accepted pattern.
// Define LED_ARB_PREEMPT_EN to let requester 0 preempt a HOLD owned by anyone else.
module led_share_arbiter
   import led_arb_pkg::*;
#(
   parameter int                NUM_REQ       = 4,
   parameter int                DATA_W        = LED_DATA_W,
   parameter int                HOLD_CYCLES   = 50_000_000,
   parameter logic [DATA_W-1:0] LED_RESET_VAL = '0
) (
   input  logic                           clk_clk,
   input  logic                           reset_reset_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]      req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [DATA_W-1:0]              led_out,
   output logic [owner_w(NUM_REQ)-1:0]    owner,
   output logic                           busy
);

   localparam int OWNER_W = owner_w(NUM_REQ);
   localparam int CNT_W   = $clog2(HOLD_CYCLES + 1);

   arb_state_t         state;
   logic [OWNER_W-1:0] rr_ptr;
   logic [CNT_W-1:0]   hold_cnt;

   logic [NUM_REQ-1:0] grant;
   logic [OWNER_W-1:0] grant_idx;
   logic               any_valid;
   logic               preempt_hit;
   logic [OWNER_W-1:0] next_ptr;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (OWNER_W)
   ) u_pick (
      .req       (req_valid),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_valid (any_valid)
   );

`ifdef LED_ARB_PREEMPT_EN
   assign preempt_hit = (state == HOLD) && (owner != '0) && req_valid[0];
`else
   assign preempt_hit = 1'b0;
`endif

   assign next_ptr = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;

   // Ready is forced low whenever reset is held so nothing can be accepted during reset.
   always_comb begin
      req_ready = '0;
      if (reset_reset_n) begin
         if (state == IDLE) begin
            req_ready = grant;
         end else if (preempt_hit) begin
            req_ready[0] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state    <= IDLE;
         led_out  <= LED_RESET_VAL;
         owner    <= '0;
         busy     <= 1'b0;
         rr_ptr   <= '0;
         hold_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  led_out  <= req_data[grant_idx*DATA_W +: DATA_W];
                  owner    <= grant_idx;
                  busy     <= 1'b1;
                  hold_cnt <= CNT_W'(HOLD_CYCLES - 1);
                  rr_ptr   <= next_ptr;
                  state    <= HOLD;
               end
            end
            HOLD: begin
               // A preemption restarts the dwell but leaves the round-robin order untouched.
               if (preempt_hit) begin
                  led_out  <= req_data[0 +: DATA_W];
                  owner    <= '0;
                  hold_cnt <= CNT_W'(HOLD_CYCLES - 1);
               end else if (hold_cnt == '0) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
